// File: rtl/psr_bank.sv
// psr_bank: banked program status register with exception entry/return sequencing.
// Holds the live status word {mode, irq_mask, flags} and one saved copy (SPSR)
// per privileged mode. Mode 0 is user mode and has no SPSR.
// Optional feature: define PSR_WRITE_EN to add a direct status-register write
// port (msr_we / msr_spsr / msr_data).
module psr_bank #(
    parameter  int NUM_BANKS = 4,
    parameter  int FLAG_W    = 4,
    localparam int MODE_W    = $clog2(NUM_BANKS),
    localparam int PSR_W     = MODE_W + 1 + FLAG_W
) (
    input  logic              clk,
    input  logic              reset,
`ifdef PSR_WRITE_EN
    input  logic              msr_we,
    input  logic              msr_spsr,
    input  logic [PSR_W-1:0]  msr_data,
`endif
    input  logic              update_flags,
    input  logic [FLAG_W-1:0] flag_mask,
    input  logic [FLAG_W-1:0] flags_temp,
    input  logic              exc_req,
    input  logic [MODE_W-1:0] exc_mode,
    output logic              exc_ack,
    input  logic              ret_req,
    output logic              ret_ack,
    output logic              err,
    output logic              busy,
    output logic [FLAG_W-1:0] flags,
    output logic [MODE_W-1:0] mode,
    output logic              irq_mask,
    output logic [PSR_W-1:0]  spsr_out
);

    typedef enum logic [1:0] {IDLE, SAVE, SWITCH, RESTORE} state_t;

    // Bank count at a width that can hold it, so mode fields compare without truncation.
    localparam logic [MODE_W:0] NB = (MODE_W + 1)'(NUM_BANKS);

    state_t              state, state_d;
    logic [MODE_W-1:0]   exc_mode_q;
    logic [PSR_W-1:0]    spsr [NUM_BANKS];
    logic                err_d;

    logic                user_mode;
    logic                exc_legal;
    logic                ret_legal;
    logic [FLAG_W-1:0]   flags_upd;
    logic [PSR_W-1:0]    spsr_cur;
    logic [MODE_W-1:0]   saved_mode;
    logic                saved_mode_ok;

    assign user_mode     = (mode == '0);
    assign exc_legal     = (exc_mode != '0) && ({1'b0, exc_mode} < NB);
    assign ret_legal     = !user_mode;
    assign flags_upd     = (flags_temp & flag_mask) | (flags & ~flag_mask);
    assign spsr_cur      = spsr[mode];
    assign saved_mode    = spsr_cur[PSR_W-1 -: MODE_W];
    assign saved_mode_ok = ({1'b0, saved_mode} < NB);
    assign spsr_out      = user_mode ? '0 : spsr_cur;
    assign busy          = (state != IDLE);

`ifdef PSR_WRITE_EN
    logic              msr_take;
    logic [MODE_W-1:0] msr_mode;
    logic              msr_mode_ok;
    assign msr_take    = msr_we && !exc_req && !ret_req;
    assign msr_mode    = msr_data[PSR_W-1 -: MODE_W];
    assign msr_mode_ok = ({1'b0, msr_mode} < NB);
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples
        // pre-edge values; blocking here would create order-dependent races.
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state, acknowledge pulses and request legality.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d = state;
        exc_ack = 1'b0;
        ret_ack = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (exc_req) begin
                    // Entry wins over return even when the entry itself is illegal.
                    if (exc_legal) state_d = SAVE;
                    else           err_d   = 1'b1;
                end else if (ret_req) begin
                    if (ret_legal) state_d = RESTORE;
                    else           err_d   = 1'b1;
                end
`ifdef PSR_WRITE_EN
                else if (msr_we && msr_spsr && user_mode) begin
                    err_d = 1'b1;
                end
`endif
            end
            SAVE:    state_d = SWITCH;
            SWITCH: begin
                exc_ack = 1'b1;
                state_d = IDLE;
            end
            RESTORE: begin
                ret_ack = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status word, SPSR bank, latched target mode and the error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags      <= '0;
            mode       <= '0;
            irq_mask   <= 1'b1;
            exc_mode_q <= '0;
            err        <= 1'b0;
            // NOTE: the SPSR bank is small and must read as zero after reset,
            // so it is cleared here like ordinary registers rather than left
            // as uninitialised RAM.
            for (int i = 0; i < NUM_BANKS; i++) spsr[i] <= '0;
        end else begin
            err <= err_d;
            case (state)
                IDLE: begin
                    if (exc_req && exc_legal) exc_mode_q <= exc_mode;
`ifdef PSR_WRITE_EN
                    if (msr_take) begin
                        if (!msr_spsr) begin
                            flags <= msr_data[FLAG_W-1:0];
                            // User mode may not raise privilege or unmask itself.
                            if (!user_mode) begin
                                mode     <= msr_mode_ok ? msr_mode : '0;
                                irq_mask <= msr_data[FLAG_W];
                            end
                        end else if (!user_mode) begin
                            spsr[mode] <= msr_data;
                        end
                    end else
`endif
                    // Applied even in an accepting cycle so SAVE sees the new flags;
                    // a return overwrites them one cycle later.
                    if (update_flags) flags <= flags_upd;
                end
                SAVE: begin
                    spsr[exc_mode_q] <= {mode, irq_mask, flags};
                end
                SWITCH: begin
                    mode     <= exc_mode_q;
                    irq_mask <= 1'b1;
                end
                RESTORE: begin
                    flags    <= spsr_cur[FLAG_W-1:0];
                    irq_mask <= spsr_cur[FLAG_W];
                    // An out-of-range saved mode falls back to user mode.
                    mode     <= saved_mode_ok ? saved_mode : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psr_bank.sv
// Self-checking bench for psr_bank (default parameters, PSR_WRITE_EN undefined).
module tb_psr_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       update_flags;
    logic [3:0] flag_mask;
    logic [3:0] flags_temp;
    logic       exc_req;
    logic [1:0] exc_mode;
    logic       exc_ack;
    logic       ret_req;
    logic       ret_ack;
    logic       err;
    logic       busy;
    logic [3:0] flags;
    logic [1:0] mode;
    logic       irq_mask;
    logic [6:0] spsr_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] flags;
        logic [1:0] mode;
        logic       irq;
        logic [6:0] spsr;
    } exp_t;

    exp_t sb[$];
    int   lat_q[$];

    psr_bank dut (
        .clk          (clk),
        .reset        (reset),
        .update_flags (update_flags),
        .flag_mask    (flag_mask),
        .flags_temp   (flags_temp),
        .exc_req      (exc_req),
        .exc_mode     (exc_mode),
        .exc_ack      (exc_ack),
        .ret_req      (ret_req),
        .ret_ack      (ret_ack),
        .err          (err),
        .busy         (busy),
        .flags        (flags),
        .mode         (mode),
        .irq_mask     (irq_mask),
        .spsr_out     (spsr_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [3:0] f, input logic [1:0] m,
                                input logic i, input logic [6:0] s);
        exp_t e;
        e.tag = tag; e.flags = f; e.mode = m; e.irq = i; e.spsr = s;
        sb.push_back(e);
    endtask

    task automatic check_state();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".flags"}, flags, e.flags);
            chk({e.tag, ".mode"}, mode, e.mode);
            chk({e.tag, ".irq_mask"}, irq_mask, e.irq);
            chk({e.tag, ".spsr_out"}, spsr_out, e.spsr);
            chk({e.tag, ".busy"}, busy, 1'b0);
        end
    endtask

    // Waits (bounded) for the acknowledge and compares its latency.
    // late_mode is driven onto exc_mode after acceptance; upd_busy drives a
    // flag update while the FSM is busy.
    task automatic wait_ack(input string tag, input bit is_exc, input logic [1:0] late_mode,
                            input bit upd_busy);
        int  n = 0;
        int  lat;
        logic ack;
        do begin
            step();
            n++;
            ack = is_exc ? exc_ack : ret_ack;
            if (n == 1) begin
                if (is_exc) exc_mode = late_mode;
                if (upd_busy) begin
                    update_flags = 1'b1; flags_temp = 4'b0000; flag_mask = 4'b1111;
                end else begin
                    update_flags = 1'b0;
                end
            end
        end while (!ack && n < 8);
        lat = lat_q.pop_front();
        chk({tag, ".ack_seen"}, ack, 1'b1);
        chk({tag, ".latency"}, n, lat);
        chk({tag, ".busy_at_ack"}, busy, 1'b1);
        exc_req = 1'b0;
        ret_req = 1'b0;
        update_flags = 1'b0;
    endtask

    task automatic do_exc(input string tag, input logic [1:0] m, input logic [1:0] late,
                          input bit upd_busy);
        exc_req  = 1'b1;
        exc_mode = m;
        lat_q.push_back(2);
        wait_ack(tag, 1'b1, late, upd_busy);
    endtask

    task automatic do_ret(input string tag);
        ret_req = 1'b1;
        lat_q.push_back(1);
        wait_ack(tag, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic flag_write(input logic [3:0] t, input logic [3:0] m);
        update_flags = 1'b1; flags_temp = t; flag_mask = m;
        step();
        update_flags = 1'b0;
    endtask

    initial begin
        reset = 1'b1; update_flags = 1'b0; flag_mask = '0; flags_temp = '0;
        exc_req = 1'b0; exc_mode = '0; ret_req = 1'b0;

        // Reset defaults.
        step(); step();
        reset = 1'b0;
        expect_state("reset", 4'b0000, 2'd0, 1'b1, 7'd0);
        check_state();
        chk("reset.err", err, 1'b0);
        chk("reset.exc_ack", exc_ack, 1'b0);

        // Masked flag update keeps C.
        expect_state("mask_upd", 4'b1101, 2'd0, 1'b1, 7'd0);
        flag_write(4'b1111, 4'b1101);
        check_state();

        expect_state("set_1010", 4'b1010, 2'd0, 1'b1, 7'd0);
        flag_write(4'b1010, 4'b1111);
        check_state();

        // Entry 0 -> 2; exc_mode changed after acceptance must be ignored.
        expect_state("entry2", 4'b1010, 2'd2, 1'b1, 7'b00_1_1010);
        do_exc("entry2", 2'd2, 2'd3, 1'b0);
        step();
        check_state();

        expect_state("m2_flags", 4'b0101, 2'd2, 1'b1, 7'b00_1_1010);
        flag_write(4'b0101, 4'b1111);
        check_state();

        // Nested entry 2 -> 1.
        expect_state("entry1", 4'b0101, 2'd1, 1'b1, 7'b10_1_0101);
        do_exc("entry1", 2'd1, 2'd1, 1'b0);
        step();
        check_state();

        // Return 1 -> 2, then 2 -> 0.
        expect_state("ret_to2", 4'b0101, 2'd2, 1'b1, 7'b00_1_1010);
        do_ret("ret_to2");
        step();
        check_state();

        expect_state("ret_to0", 4'b1010, 2'd0, 1'b1, 7'd0);
        do_ret("ret_to0");
        step();
        check_state();

        // Illegal return from user mode.
        ret_req = 1'b1;
        step();
        ret_req = 1'b0;
        chk("ill_ret.err", err, 1'b1);
        chk("ill_ret.busy", busy, 1'b0);
        step();
        chk("ill_ret.err_pulse", err, 1'b0);
        expect_state("ill_ret", 4'b1010, 2'd0, 1'b1, 7'd0);
        check_state();

        // Illegal entry to mode 0.
        exc_req = 1'b1; exc_mode = 2'd0;
        step();
        exc_req = 1'b0;
        chk("ill_exc.err", err, 1'b1);
        chk("ill_exc.busy", busy, 1'b0);
        step();
        chk("ill_exc.err_pulse", err, 1'b0);
        expect_state("ill_exc", 4'b1010, 2'd0, 1'b1, 7'd0);
        check_state();

        // Simultaneous entry and return: entry wins.
        ret_req = 1'b1;
        expect_state("prio", 4'b1010, 2'd3, 1'b1, 7'b00_1_1010);
        do_exc("prio", 2'd3, 2'd3, 1'b0);
        chk("prio.err", err, 1'b0);
        step();
        check_state();

        // Re-entry into mode 3 with flag updates while busy (ignored).
        expect_state("reentry", 4'b1010, 2'd3, 1'b1, 7'b11_1_1010);
        do_exc("reentry", 2'd3, 2'd3, 1'b1);
        step();
        check_state();

        // Flag update in the accepting cycle is captured by SAVE.
        update_flags = 1'b1; flags_temp = 4'b0110; flag_mask = 4'b1111;
        expect_state("upd_accept", 4'b0110, 2'd1, 1'b1, 7'b11_1_0110);
        do_exc("upd_accept", 2'd1, 2'd1, 1'b0);
        step();
        check_state();

        // Reset during SAVE: immediate defaults, no acknowledge.
        exc_req = 1'b1; exc_mode = 2'd2;
        step();
        chk("midrst.busy_save", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.mode", mode, 2'd0);
        chk("midrst.flags", flags, 4'b0000);
        chk("midrst.irq_mask", irq_mask, 1'b1);
        chk("midrst.exc_ack", exc_ack, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("midrst.no_ack", exc_ack, 1'b0);
        end
        exc_req = 1'b0;
        reset = 1'b0;
        step();
        expect_state("after_rst", 4'b0000, 2'd0, 1'b1, 7'd0);
        check_state();
        chk("after_rst.exc_ack", exc_ack, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
